round_controller: RTL and testbench

- Game-round sequencer sitting directly upstream of the order/score stage.
- Generates the timer_go enable and a one-cycle round_reset pulse that clears the scoring stage at the start of each round.
- Runs the 3-2-1 pre-round countdown, the round clock and pause, and latches the final score and high score from point_total when the round ends.
- All timing runs off the 25.175 MHz pixel clock.

---
 rtl/game_pkg.sv | 18 +
 rtl/edge_pulse.sv | 27 ++
 rtl/round_controller.sv | 182 ++++++++++++++++++
 tb/tb_round_controller.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the game-round sequencer.
//   game_state_t   : round sequencer states, encoded as seen on game_state
//   ONE_SEC_CYCLES : pixel-clock cycles per second (25.175 MHz)
//   SCORE_W        : width of the two's-complement score bus
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COUNTDOWN = 3'd1,
        ST_PLAYING   = 3'd2,
        ST_PAUSED    = 3'd3,
        ST_OVER      = 3'd4
    } game_state_t;

    localparam int ONE_SEC_CYCLES = 25175000;
    localparam int SCORE_W        = 10;

endpackage : game_pkg

// File: rtl/edge_pulse.sv
// Rising-edge detector for a debounced button level.
//   clock : system clock
//   reset : asynchronous, active-high reset (clears the history flop)
//   btn   : debounced button level
//   pulse : high while btn is 1 and the previous sampled level was 0
// The pulse is combinational from the live level and the registered history,
// so the consumer acts at the same edge that captures btn_q = 1.
module edge_pulse (
    input  logic clock,
    input  logic reset,
    input  logic btn,
    output logic pulse
);

    logic btn_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            btn_q <= 1'b0;
        end else begin
            btn_q <= btn;
        end
    end

    assign pulse = btn & ~btn_q;

endmodule : edge_pulse

// File: rtl/round_controller.sv
// Game-round sequencer: start/pause handling, 3-2-1 pre-round countdown,
// round clock, and final/high score latching.
//   clock, reset  : pixel clock, asynchronous active-high reset
//   start_btn     : debounced level, rising edge starts a round
//   pause_btn     : debounced level, rising edge toggles pause
//   point_total   : running score (two's complement) from the scoring stage
//   timer_go      : high only while PLAYING
//   round_reset   : one-cycle pulse on entry to COUNTDOWN
//   game_state    : IDLE=0, COUNTDOWN=1, PLAYING=2, PAUSED=3, OVER=4
//   countdown     : pre-round seconds remaining
//   time_left     : round seconds remaining
//   second_tick   : one-cycle pulse per counted second
//   final_score   : point_total latched when the round ends
//   high_score    : best final score since reset (signed compare)
module round_controller
    import game_pkg::*;
#(
    parameter int ONE_SEC           = ONE_SEC_CYCLES,
    parameter int ROUND_SECONDS     = 150,
    parameter int COUNTDOWN_SECONDS = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start_btn,
    input  logic               pause_btn,
    input  logic [SCORE_W-1:0] point_total,
    output logic               timer_go,
    output logic               round_reset,
    output logic [2:0]         game_state,
    output logic [1:0]         countdown,
    output logic [7:0]         time_left,
    output logic               second_tick,
    output logic [SCORE_W-1:0] final_score,
    output logic [SCORE_W-1:0] high_score
);

    localparam int SEC_W = (ONE_SEC > 1) ? $clog2(ONE_SEC) : 1;
    localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(ONE_SEC - 1);

    // Button edge detection: index 0 = start, index 1 = pause.
    logic [1:0] btn_level;
    logic [1:0] btn_pulse;

    assign btn_level = {pause_btn, start_btn};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            edge_pulse u_edge (
                .clock (clock),
                .reset (reset),
                .btn   (btn_level[gi]),
                .pulse (btn_pulse[gi])
            );
        end
    endgenerate

    logic start_pulse;
    logic pause_pulse;

    assign start_pulse = btn_pulse[0];
    assign pause_pulse = btn_pulse[1];

    game_state_t        state_reg,       state_next;
    logic [SEC_W-1:0]   sec_reg,         sec_next;
    logic [1:0]         countdown_reg,   countdown_next;
    logic [7:0]         time_left_reg,   time_left_next;
    logic [SCORE_W-1:0] final_reg,       final_next;
    logic [SCORE_W-1:0] high_reg,        high_next;
    logic               timer_go_reg,    timer_go_next;
    logic               round_reset_reg, round_reset_next;
    logic               tick_reg,        tick_next;

    logic counting;
    logic tick;

    // The second counter only runs while a timed phase is active; PAUSED
    // freezes it so resuming continues the partially elapsed second.
    assign counting = (state_reg == ST_COUNTDOWN) || (state_reg == ST_PLAYING);
    assign tick     = counting && (sec_reg == SEC_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            sec_reg         <= '0;
            countdown_reg   <= '0;
            time_left_reg   <= '0;
            final_reg       <= '0;
            high_reg        <= '0;
            timer_go_reg    <= 1'b0;
            round_reset_reg <= 1'b0;
            tick_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            sec_reg         <= sec_next;
            countdown_reg   <= countdown_next;
            time_left_reg   <= time_left_next;
            final_reg       <= final_next;
            high_reg        <= high_next;
            timer_go_reg    <= timer_go_next;
            round_reset_reg <= round_reset_next;
            tick_reg        <= tick_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        countdown_next   = countdown_reg;
        time_left_next   = time_left_reg;
        final_next       = final_reg;
        high_next        = high_reg;
        round_reset_next = 1'b0;
        tick_next        = tick;

        case (state_reg)
            ST_COUNTDOWN, ST_PLAYING: sec_next = tick ? '0 : sec_reg + 1'b1;
            ST_PAUSED:                sec_next = sec_reg;
            default:                  sec_next = '0;
        endcase

        case (state_reg)
            ST_IDLE, ST_OVER: begin
                // Start has priority over a coincident pause, which is
                // meaningless here anyway.
                if (start_pulse) begin
                    state_next       = ST_COUNTDOWN;
                    countdown_next   = 2'(COUNTDOWN_SECONDS);
                    time_left_next   = 8'(ROUND_SECONDS);
                    sec_next         = '0;
                    round_reset_next = 1'b1;
                end
            end
            ST_COUNTDOWN: begin
                if (tick) begin
                    if (countdown_reg > 2'd1) begin
                        countdown_next = countdown_reg - 2'd1;
                    end else begin
                        countdown_next = 2'd0;
                        state_next     = ST_PLAYING;
                    end
                end
            end
            ST_PLAYING: begin
                // A tick landing with a pause press wins; the press is lost.
                if (tick) begin
                    if (time_left_reg > 8'd1) begin
                        time_left_next = time_left_reg - 8'd1;
                    end else begin
                        time_left_next = 8'd0;
                        state_next     = ST_OVER;
                        final_next     = point_total;
                        if ($signed(point_total) > $signed(high_reg)) begin
                            high_next = point_total;
                        end
                    end
                end else if (pause_pulse) begin
                    state_next = ST_PAUSED;
                end
            end
            ST_PAUSED: begin
                if (pause_pulse) begin
                    state_next = ST_PLAYING;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Registered from the next state so it lines up with game_state.
        timer_go_next = (state_next == ST_PLAYING);
    end

    assign game_state  = state_reg;
    assign timer_go    = timer_go_reg;
    assign round_reset = round_reset_reg;
    assign countdown   = countdown_reg;
    assign time_left   = time_left_reg;
    assign second_tick = tick_reg;
    assign final_score = final_reg;
    assign high_score  = high_reg;

endmodule : round_controller

// File: tb/tb_round_controller.sv
module tb_round_controller;

    logic       clock = 1'b0;
    logic       reset;
    logic       start_btn;
    logic       pause_btn;
    logic [9:0] point_total;
    logic       timer_go;
    logic       round_reset;
    logic [2:0] game_state;
    logic [1:0] countdown;
    logic [7:0] time_left;
    logic       second_tick;
    logic [9:0] final_score;
    logic [9:0] high_score;

    round_controller #(
        .ONE_SEC           (5),
        .ROUND_SECONDS     (4),
        .COUNTDOWN_SECONDS (3)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start_btn   (start_btn),
        .pause_btn   (pause_btn),
        .point_total (point_total),
        .timer_go    (timer_go),
        .round_reset (round_reset),
        .game_state  (game_state),
        .countdown   (countdown),
        .time_left   (time_left),
        .second_tick (second_tick),
        .final_score (final_score),
        .high_score  (high_score)
    );

    always #5 clock = ~clock;

    // Number of rising clock edges seen so far; events are labelled by it.
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct packed {
        int         cyc;
        logic [2:0] st;
        logic [1:0] cd;
        logic [7:0] tl;
        logic       go;
        logic       rr;
        logic       tk;
        logic [9:0] fs;
        logic [9:0] hs;
    } ev_t;

    ev_t exp_q[$];
    int  errors = 0;
    int  checks = 0;

    task automatic push_ev(input int c, input logic [2:0] st, input logic [1:0] cd,
                           input logic [7:0] tl, input logic go, input logic rr,
                           input logic tk, input logic [9:0] fs, input logic [9:0] hs);
        ev_t e;
        e.cyc = c; e.st = st; e.cd = cd; e.tl = tl;
        e.go = go; e.rr = rr; e.tk = tk; e.fs = fs; e.hs = hs;
        exp_q.push_back(e);
    endtask

    // Countdown phase of a round whose start edge is s (ROUND_SECONDS=4).
    task automatic push_countdown(input int s, input logic [9:0] fs, input logic [9:0] hs);
        push_ev(s,      3'd1, 2'd3, 8'd4, 1'b0, 1'b1, 1'b0, fs, hs);
        push_ev(s + 5,  3'd1, 2'd2, 8'd4, 1'b0, 1'b0, 1'b1, fs, hs);
        push_ev(s + 10, 3'd1, 2'd1, 8'd4, 1'b0, 1'b0, 1'b1, fs, hs);
        push_ev(s + 15, 3'd2, 2'd0, 8'd4, 1'b1, 1'b0, 1'b1, fs, hs);
    endtask

    // Uninterrupted playing phase entered at edge p.
    task automatic push_play(input int p, input logic [9:0] ofs, input logic [9:0] ohs,
                             input logic [9:0] nfs, input logic [9:0] nhs);
        push_ev(p + 5,  3'd2, 2'd0, 8'd3, 1'b1, 1'b0, 1'b1, ofs, ohs);
        push_ev(p + 10, 3'd2, 2'd0, 8'd2, 1'b1, 1'b0, 1'b1, ofs, ohs);
        push_ev(p + 15, 3'd2, 2'd0, 8'd1, 1'b1, 1'b0, 1'b1, ofs, ohs);
        push_ev(p + 20, 3'd4, 2'd0, 8'd0, 1'b0, 1'b0, 1'b1, nfs, nhs);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s = %0d", name, act);
        end
    endtask

    // Plain round: start edge two cycles from now, optional pause pressed with start.
    task automatic run_round(input logic [9:0] pt, input logic [9:0] ofs, input logic [9:0] ohs,
                             input logic [9:0] nhs, input bit with_pause, input bit hold_start);
        int s;
        s = cyc + 2;
        point_total = pt;
        push_countdown(s, ofs, ohs);
        push_play(s + 15, ofs, ohs, pt, nhs);
        wait_cyc(s - 1);
        start_btn = 1'b1;
        pause_btn = with_pause;
        wait_cyc(s + 2);
        pause_btn = 1'b0;
        if (!hold_start) start_btn = 1'b0;
        wait_cyc(s + 40);
        start_btn = 1'b0;
        wait_cyc(s + 42);
    endtask

    // Monitor: any cycle with a state change, round_reset or second_tick is an event.
    logic [2:0] prev_state = 3'd0;
    always @(negedge clock) begin
        ev_t got;
        ev_t e;
        if (round_reset || second_tick || (game_state != prev_state)) begin
            got.cyc = cyc; got.st = game_state; got.cd = countdown; got.tl = time_left;
            got.go = timer_go; got.rr = round_reset; got.tk = second_tick;
            got.fs = final_score; got.hs = high_score;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: got cyc=%0d st=%0d cd=%0d tl=%0d go=%0d rr=%0d tk=%0d fs=%h hs=%h, none expected",
                         got.cyc, got.st, got.cd, got.tl, got.go, got.rr, got.tk, got.fs, got.hs);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL event: got cyc=%0d st=%0d cd=%0d tl=%0d go=%0d rr=%0d tk=%0d fs=%h hs=%h expected cyc=%0d st=%0d cd=%0d tl=%0d go=%0d rr=%0d tk=%0d fs=%h hs=%h",
                             got.cyc, got.st, got.cd, got.tl, got.go, got.rr, got.tk, got.fs, got.hs,
                             e.cyc, e.st, e.cd, e.tl, e.go, e.rr, e.tk, e.fs, e.hs);
                end else begin
                    $display("ok   event cyc=%0d st=%0d cd=%0d tl=%0d go=%0d rr=%0d tk=%0d fs=%h hs=%h",
                             got.cyc, got.st, got.cd, got.tl, got.go, got.rr, got.tk, got.fs, got.hs);
                end
            end
        end
        prev_state = game_state;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int p;
        reset       = 1'b1;
        start_btn   = 1'b0;
        pause_btn   = 1'b0;
        point_total = 10'd0;
        wait_cyc(3);
        check("reset_state",       32'(game_state),  32'd0);
        check("reset_timer_go",    32'(timer_go),    32'd0);
        check("reset_round_reset", 32'(round_reset), 32'd0);
        check("reset_countdown",   32'(countdown),   32'd0);
        check("reset_time_left",   32'(time_left),   32'd0);
        check("reset_final",       32'(final_score), 32'd0);
        check("reset_high",        32'(high_score),  32'd0);
        reset = 1'b0;
        wait_cyc(6);

        // Round 1: start held through the whole round, score 37.
        run_round(10'd37, 10'd0, 10'd0, 10'd37, 1'b0, 1'b1);

        // Round 2: pause at PLAYING+7, resume 50 cycles later, score -10.
        s = cyc + 2;
        p = s + 15;
        point_total = 10'h3F6;
        push_countdown(s, 10'd37, 10'd37);
        push_ev(p + 5,  3'd2, 2'd0, 8'd3, 1'b1, 1'b0, 1'b1, 10'd37, 10'd37);
        push_ev(p + 7,  3'd3, 2'd0, 8'd3, 1'b0, 1'b0, 1'b0, 10'd37, 10'd37);
        push_ev(p + 57, 3'd2, 2'd0, 8'd3, 1'b1, 1'b0, 1'b0, 10'd37, 10'd37);
        push_ev(p + 60, 3'd2, 2'd0, 8'd2, 1'b1, 1'b0, 1'b1, 10'd37, 10'd37);
        push_ev(p + 65, 3'd2, 2'd0, 8'd1, 1'b1, 1'b0, 1'b1, 10'd37, 10'd37);
        push_ev(p + 70, 3'd4, 2'd0, 8'd0, 1'b0, 1'b0, 1'b1, 10'h3F6, 10'd37);
        wait_cyc(s - 1);  start_btn = 1'b1;
        wait_cyc(s + 2);  start_btn = 1'b0;
        wait_cyc(p + 6);  pause_btn = 1'b1;
        wait_cyc(p + 7);  pause_btn = 1'b0;
        wait_cyc(p + 56); pause_btn = 1'b1;
        wait_cyc(p + 57); pause_btn = 1'b0;
        wait_cyc(p + 75);

        // Round 3: score 50, pause pressed on the final tick -> OVER wins.
        s = cyc + 2;
        point_total = 10'd50;
        push_countdown(s, 10'h3F6, 10'd37);
        push_play(s + 15, 10'h3F6, 10'd37, 10'd50, 10'd50);
        wait_cyc(s - 1);  start_btn = 1'b1;
        wait_cyc(s + 2);  start_btn = 1'b0;
        wait_cyc(s + 34); pause_btn = 1'b1;
        wait_cyc(s + 35); pause_btn = 1'b0;
        wait_cyc(s + 42);

        // Round 4: start+pause together in OVER, then async reset mid-PLAYING.
        s = cyc + 2;
        push_countdown(s, 10'd50, 10'd50);
        wait_cyc(s - 1);  start_btn = 1'b1; pause_btn = 1'b1;
        wait_cyc(s + 2);  start_btn = 1'b0; pause_btn = 1'b0;
        wait_cyc(s + 18);
        push_ev(s + 18, 3'd0, 2'd0, 8'd0, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0);
        #2 reset = 1'b1;
        #1;
        check("async_reset_state",    32'(game_state),  32'd0);
        check("async_reset_timer_go", 32'(timer_go),    32'd0);
        check("async_reset_time",     32'(time_left),   32'd0);
        check("async_reset_final",    32'(final_score), 32'd0);
        check("async_reset_high",     32'(high_score),  32'd0);
        wait_cyc(s + 20);
        reset = 1'b0;
        wait_cyc(s + 40);

        // Round 5: start+pause together in IDLE, score 5.
        run_round(10'd5, 10'd0, 10'd0, 10'd5, 1'b1, 1'b0);

        wait_cyc(cyc + 10);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_round_controller
